// File: rtl/spdif_encoder.sv
// spdif_encoder: biphase-mark stereo PCM serialiser.
// Emits 32-slot B/M/W subframes in 192-frame blocks.
module spdif_encoder #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] sample_left,
  input  logic [DATA_W-1:0] sample_right,
  input  logic [31:0]       chstat,
  output logic              tx_out,
  output logic              frame_start,
  output logic              block_start,
  output logic              underrun
);

  localparam int DW = $clog2(CLK_DIV);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  logic [0:0]        state;
  logic [DW-1:0]     div;
  logic [6:0]        hc;
  logic [7:0]        fidx;
  logic              hold_full;
  logic              hold_full_n;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [31:0]       word_l;
  logic [31:0]       word_r;
  logic              inv;

  logic        take;
  logic        tick;
  logic        fstart;
  logic        last_div;
  logic        is_pre;
  logic [4:0]  slot;
  logic [31:0] cur_word;
  logic [7:0]  pat;
  logic        inv_now;
  logic        c_bit;
  logic        tx_n;

  // Slots 4..27 hold the MSB-aligned sample; P makes 4..31 even.
  function automatic logic [31:0] mk_word(
    input logic [DATA_W-1:0] s,
    input logic              v,
    input logic              c
  );
    logic [23:0] a;
    logic [31:0] w;
    a = '0;
    a[23 -: DATA_W] = s;
    w = {1'b0, c, 1'b0, v, a, 4'b0000};
    w[31] = ^w[30:4];
    return w;
  endfunction

  assign take     = sample_valid & sample_ready;
  assign last_div = (div == DW'(CLK_DIV - 1));
  assign tick     = (state == S_RUN) && (div == '0) && ena;
  assign fstart   = tick && (hc == 7'd0);
  assign slot     = hc[5:1];
  assign is_pre   = (hc[5:3] == 3'd0);
  assign cur_word = hc[6] ? word_r : word_l;
  assign c_bit    = (fidx < 8'd32) ? chstat[fidx[4:0]] : 1'b0;

  assign pat = hc[6] ? PRE_W :
               ((fidx == 8'd0) ? PRE_B : PRE_M);

  // Preamble polarity follows the level left by the previous cell.
  assign inv_now = (hc[2:0] == 3'd0) ? tx_out : inv;

  always_comb begin
    hold_full_n = hold_full;
    if (fstart) hold_full_n = 1'b0;
    if (take)   hold_full_n = 1'b1;
  end

  always_comb begin
    tx_n = tx_out;
    unique case (1'b1)
      is_pre:
        tx_n = pat[3'd7 - hc[2:0]] ^ inv_now;
      (!is_pre && !hc[0]):
        tx_n = ~tx_out;
      (!is_pre && hc[0]):
        tx_n = tx_out ^ cur_word[slot];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      div          <= '0;
      hc           <= '0;
      fidx         <= '0;
      hold_full    <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      word_l       <= '0;
      word_r       <= '0;
      inv          <= 1'b0;
      tx_out       <= 1'b0;
      sample_ready <= 1'b0;
      frame_start  <= 1'b0;
      block_start  <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_start  <= 1'b0;
      block_start  <= 1'b0;
      underrun     <= 1'b0;
      hold_full    <= hold_full_n;
      sample_ready <= ~hold_full_n;
      if (take) begin
        hold_l <= sample_left;
        hold_r <= sample_right;
      end
      if (state == S_IDLE || !ena) begin
        tx_out <= 1'b0;
        div    <= '0;
        hc     <= '0;
        fidx   <= '0;
        state  <= ena ? S_RUN : S_IDLE;
      end else begin
        div <= last_div ? '0 : div + DW'(1);
        if (last_div) begin
          hc <= hc + 7'd1;
          if (hc == 7'd127)
            fidx <= (fidx == 8'd191) ? 8'd0 : fidx + 8'd1;
        end
        if (tick) begin
          tx_out <= tx_n;
          if (is_pre && hc[2:0] == 3'd0)
            inv <= tx_out;
        end
        if (fstart) begin
          frame_start <= 1'b1;
          block_start <= (fidx == 8'd0);
          underrun    <= ~hold_full;
          if (hold_full) begin
            word_l <= mk_word(hold_l, 1'b0, c_bit);
            word_r <= mk_word(hold_r, 1'b0, c_bit);
          end else begin
            word_l <= mk_word('0, 1'b1, c_bit);
            word_r <= mk_word('0, 1'b1, c_bit);
          end
        end
      end
    end
  end

endmodule
